// File: rtl/cache_request_generator_mc.sv
// rtl/cache_request_generator_mc.sv - multi-channel round-robin cache request generator
// Channels are arbitrated into a request FIFO and issued through one output register, with in-flight requests bounded by credits.
module cache_request_generator_mc #(
    parameter int NUM_CHANNELS    = 4,
    parameter int ADDR_W          = 64,
    parameter int DATA_W          = 512,
    parameter int FIFO_DEPTH      = 16,
    parameter int OUTSTANDING_MAX = 16,
    parameter int ID_W            = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                                  ap_clk,
    input  logic                                  areset,
    input  logic [NUM_CHANNELS-1:0]               req_valid,
    output logic [NUM_CHANNELS-1:0]               req_ready,
    input  logic [NUM_CHANNELS*ADDR_W-1:0]        req_base,
    input  logic [NUM_CHANNELS*ADDR_W-1:0]        req_offset,
    input  logic [NUM_CHANNELS-1:0]               req_we,
    input  logic [NUM_CHANNELS*DATA_W-1:0]        req_wdata,
    input  logic [NUM_CHANNELS*(DATA_W/8)-1:0]    req_wstrb,
    output logic                                  cache_req_valid,
    input  logic                                  cache_req_ready,
    output logic [ADDR_W-1:0]                     cache_req_addr,
    output logic                                  cache_req_we,
    output logic [DATA_W-1:0]                     cache_req_wdata,
    output logic [DATA_W/8-1:0]                   cache_req_wstrb,
    output logic [ID_W-1:0]                       cache_req_id,
    input  logic                                  cache_resp_valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]       fifo_fill,
    output logic [$clog2(OUTSTANDING_MAX+1)-1:0]  outstanding_count,
    output logic                                  credit_error,
    output logic                                  fifo_setup_signal
);
    localparam int STRB_W = DATA_W / 8;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FILL_W = $clog2(FIFO_DEPTH + 1);
    localparam int CRED_W = $clog2(OUTSTANDING_MAX + 1);

    logic [1:0]        setup_cnt_q, setup_cnt_d;
    logic              setup_done;
    logic [ID_W-1:0]   rr_q, rr_d, win_idx;
    logic              win_found, grant;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_we;
    logic [DATA_W-1:0] sel_wdata;
    logic [STRB_W-1:0] sel_wstrb;
    logic [ADDR_W-1:0] fifo_addr  [FIFO_DEPTH];
    logic              fifo_we    [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_wdata [FIFO_DEPTH];
    logic [STRB_W-1:0] fifo_wstrb [FIFO_DEPTH];
    logic [ID_W-1:0]   fifo_id    [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [FILL_W-1:0] count_q, count_d;
    logic              fifo_full, fifo_empty, push, pop;
    logic              out_valid_q, out_we_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic [DATA_W-1:0] out_wdata_q;
    logic [STRB_W-1:0] out_wstrb_q;
    logic [ID_W-1:0]   out_id_q;
    logic [CRED_W-1:0] outstanding_q, outstanding_d;
    logic [CRED_W:0]   cred_pred;
    logic              credit_err_q, credit_err_d;
    logic              fire, resp_ok, load;

    // Setup counter: two cycles after reset release before anything is accepted or issued.
    assign setup_done = (setup_cnt_q == 2'd2);

    always_comb begin
        setup_cnt_d = setup_cnt_q;
        if (!setup_done) setup_cnt_d = setup_cnt_q + 2'd1;
    end

    always_ff @(posedge ap_clk) begin
        if (areset) setup_cnt_q <= 2'd0;
        else        setup_cnt_q <= setup_cnt_d;
    end

    // First pass searches from the pointer upward, second pass wraps to the low indices.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (!win_found && req_valid[i] && (i >= int'(rr_q))) begin
                win_found = 1'b1;
                win_idx   = ID_W'(i);
            end
        end
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (!win_found && req_valid[i]) begin
                win_found = 1'b1;
                win_idx   = ID_W'(i);
            end
        end
    end

    assign grant = win_found && setup_done && !fifo_full;
    assign push  = grant;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            req_ready[i] = grant && (win_idx == ID_W'(i));
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (grant) rr_d = (win_idx == ID_W'(NUM_CHANNELS - 1)) ? '0 : win_idx + ID_W'(1);
    end

    always_ff @(posedge ap_clk) begin
        if (areset) rr_q <= '0;
        else        rr_q <= rr_d;
    end

    always_comb begin
        sel_addr  = '0;
        sel_we    = 1'b0;
        sel_wdata = '0;
        sel_wstrb = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (win_idx == ID_W'(i)) begin
                sel_addr  = req_base[i*ADDR_W +: ADDR_W] + req_offset[i*ADDR_W +: ADDR_W];
                sel_we    = req_we[i];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
                sel_wstrb = req_wstrb[i*STRB_W +: STRB_W];
            end
        end
    end

    assign fifo_full  = (count_q == FILL_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign pop        = load;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + FILL_W'(1);
            2'b01:   count_d = count_q - FILL_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (push) begin
            fifo_addr[wr_ptr_q]  <= sel_addr;
            fifo_we[wr_ptr_q]    <= sel_we;
            fifo_wdata[wr_ptr_q] <= sel_wdata;
            fifo_wstrb[wr_ptr_q] <= sel_wstrb;
            fifo_id[wr_ptr_q]    <= win_idx;
        end
    end

    // A request is only loaded when its credit is already guaranteed, so the output
    // register can present valid without further gating and never issues at the limit.
    assign fire      = out_valid_q && cache_req_ready;
    assign resp_ok   = cache_resp_valid && (outstanding_q != '0);
    assign cred_pred = {1'b0, outstanding_q} + {{CRED_W{1'b0}}, fire} - {{CRED_W{1'b0}}, resp_ok};
    assign load      = setup_done && !fifo_empty && (!out_valid_q || cache_req_ready)
                       && (cred_pred < (CRED_W+1)'(OUTSTANDING_MAX));

    assign outstanding_d = cred_pred[CRED_W-1:0];
    assign credit_err_d  = credit_err_q | (cache_resp_valid && (outstanding_q == '0));

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            outstanding_q <= '0;
            credit_err_q  <= 1'b0;
        end else begin
            outstanding_q <= outstanding_d;
            credit_err_q  <= credit_err_d;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_we_q    <= 1'b0;
            out_wdata_q <= '0;
            out_wstrb_q <= '0;
            out_id_q    <= '0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            out_addr_q  <= fifo_addr[rd_ptr_q];
            out_we_q    <= fifo_we[rd_ptr_q];
            out_wdata_q <= fifo_wdata[rd_ptr_q];
            out_wstrb_q <= fifo_wstrb[rd_ptr_q];
            out_id_q    <= fifo_id[rd_ptr_q];
        end else if (fire) begin
            out_valid_q <= 1'b0;
        end
    end

    assign cache_req_valid   = out_valid_q;
    assign cache_req_addr    = out_addr_q;
    assign cache_req_we      = out_we_q;
    assign cache_req_wdata   = out_wdata_q;
    assign cache_req_wstrb   = out_wstrb_q;
    assign cache_req_id      = out_id_q;
    assign fifo_fill         = count_q;
    assign outstanding_count = outstanding_q;
    assign credit_error      = credit_err_q;
    assign fifo_setup_signal = !setup_done;

endmodule

// File: tb/tb_cache_request_generator_mc.sv
// tb/tb_cache_request_generator_mc.sv - directed self-checking bench for cache_request_generator_mc
module tb_cache_request_generator_mc;
    localparam int N  = 4;
    localparam int AW = 64;
    localparam int DW = 512;
    localparam int SW = DW / 8;
    localparam int FD = 16;
    localparam int OM = 4;
    localparam int IW = 2;

    logic            ap_clk = 1'b0;
    logic            areset = 1'b1;
    logic [N-1:0]    req_valid, req_ready, req_we;
    logic [N*AW-1:0] req_base, req_offset;
    logic [N*DW-1:0] req_wdata;
    logic [N*SW-1:0] req_wstrb;
    logic            cache_req_valid, cache_req_ready, cache_req_we, cache_resp_valid;
    logic [AW-1:0]   cache_req_addr;
    logic [DW-1:0]   cache_req_wdata;
    logic [SW-1:0]   cache_req_wstrb;
    logic [IW-1:0]   cache_req_id;
    logic [4:0]      fifo_fill;
    logic [2:0]      outstanding_count;
    logic            credit_error, fifo_setup_signal;

    int checks = 0;
    int errors = 0;
    int rem [N];
    int seq [N];
    bit auto_resp;
    int cyc;
    logic [AW-1:0] log_addr [$];
    logic [IW-1:0] log_id [$];
    int            log_cyc [$];

    always #5 ap_clk = ~ap_clk;

    cache_request_generator_mc #(
        .NUM_CHANNELS(N), .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(FD), .OUTSTANDING_MAX(OM)
    ) dut (
        .ap_clk(ap_clk), .areset(areset),
        .req_valid(req_valid), .req_ready(req_ready), .req_base(req_base), .req_offset(req_offset),
        .req_we(req_we), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .cache_req_valid(cache_req_valid), .cache_req_ready(cache_req_ready),
        .cache_req_addr(cache_req_addr), .cache_req_we(cache_req_we),
        .cache_req_wdata(cache_req_wdata), .cache_req_wstrb(cache_req_wstrb),
        .cache_req_id(cache_req_id), .cache_resp_valid(cache_resp_valid),
        .fifo_fill(fifo_fill), .outstanding_count(outstanding_count),
        .credit_error(credit_error), .fifo_setup_signal(fifo_setup_signal)
    );

    // Generated request: base = {channel, seq}, offset 0x100, read, full strobes.
    task automatic load_gen(input int c);
        req_valid[c]             = 1'b1;
        req_base[c*AW +: AW]     = (64'(c) << 32) | 64'(seq[c]);
        req_offset[c*AW +: AW]   = 64'h100;
        req_we[c]                = 1'b0;
        req_wdata[c*DW +: DW]    = '0;
        req_wstrb[c*SW +: SW]    = '1;
    endtask

    task automatic cycle();
        logic [N-1:0] acc;
        logic         fire;
        @(negedge ap_clk);
        acc  = req_valid & req_ready;
        fire = cache_req_valid & cache_req_ready;
        if (fire) begin
            log_addr.push_back(cache_req_addr);
            log_id.push_back(cache_req_id);
            log_cyc.push_back(cyc);
        end
        @(posedge ap_clk); #1;
        cyc++;
        for (int c = 0; c < N; c++) begin
            if (acc[c]) begin
                rem[c]--;
                seq[c]++;
                if (rem[c] > 0) load_gen(c);
                else req_valid[c] = 1'b0;
            end
        end
        if (auto_resp) cache_resp_valid = fire;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        req_valid = '0; req_we = '0; req_base = '0; req_offset = '0; req_wdata = '0; req_wstrb = '0;
        cache_req_ready = 1'b0; cache_resp_valid = 1'b0; auto_resp = 1'b0;
        for (int c = 0; c < N; c++) begin rem[c] = 0; seq[c] = 0; end
        log_addr.delete(); log_id.delete(); log_cyc.delete();
        @(posedge ap_clk); @(posedge ap_clk); #1;
        areset = 1'b0;
        @(posedge ap_clk); #1;
        @(posedge ap_clk); #1;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        req_we = '0; req_base = '0; req_offset = '0; req_wdata = '0; req_wstrb = '0;
        req_valid = '1; cache_req_ready = 1'b1; cache_resp_valid = 1'b0;
        repeat (2) @(posedge ap_clk); #1;
        checks++; if (fifo_setup_signal !== 1'b1) begin errors++; $display("FAIL reset_setup got %0b exp 1", fifo_setup_signal); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
        checks++; if (cache_req_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", cache_req_valid); end
        checks++; if (fifo_fill !== 5'd0 || outstanding_count !== 3'd0 || credit_error !== 1'b0 || cache_req_addr !== 64'd0)
            begin errors++; $display("FAIL reset_outputs got fill %0d out %0d err %0b addr %h exp all 0", fifo_fill, outstanding_count, credit_error, cache_req_addr); end
        areset = 1'b0;
        @(posedge ap_clk); #1;
        checks++; if (fifo_setup_signal !== 1'b1 || req_ready !== 4'b0000)
            begin errors++; $display("FAIL setup_cycle1 got setup %0b ready %b exp 1 0000", fifo_setup_signal, req_ready); end
        @(posedge ap_clk); #1;
        checks++; if (fifo_setup_signal !== 1'b0 || req_ready !== 4'b0001)
            begin errors++; $display("FAIL setup_done got setup %0b ready %b exp 0 0001", fifo_setup_signal, req_ready); end
        req_valid = '0;
    endtask

    task automatic test_round_robin();
        int span;
        do_reset();
        for (int c = 0; c < N; c++) begin rem[c] = 4; load_gen(c); end
        cache_req_ready = 1'b1; auto_resp = 1'b1;
        for (int i = 0; i < 60 && log_id.size() < 16; i++) cycle();
        repeat (3) cycle();
        checks++; if (log_id.size() != 16) begin errors++; $display("FAIL rr_count got %0d exp 16", log_id.size()); end
        for (int i = 0; i < log_id.size(); i++) begin
            checks++; if (log_id[i] !== IW'(i % 4)) begin errors++; $display("FAIL rr_id[%0d] got %0d exp %0d", i, log_id[i], i % 4); end
            checks++; if (log_addr[i] !== (64'(i % 4) << 32) + 64'h100 + 64'(i / 4))
                begin errors++; $display("FAIL rr_addr[%0d] got %h exp %h", i, log_addr[i], (64'(i % 4) << 32) + 64'h100 + 64'(i / 4)); end
        end
        span = (log_cyc.size() >= 16) ? log_cyc[15] - log_cyc[0] : -1;
        checks++; if (span != 15) begin errors++; $display("FAIL rr_throughput got span %0d exp 15", span); end
        checks++; if (outstanding_count !== 3'd0 || credit_error !== 1'b0)
            begin errors++; $display("FAIL rr_credits got out %0d err %0b exp 0 0", outstanding_count, credit_error); end
    endtask

    task automatic test_addr_wrap();
        do_reset();
        req_base[0 +: AW] = 64'hFFFF_FFFF_FFFF_FFF0; req_offset[0 +: AW] = 64'h20; req_valid[0] = 1'b1;
        @(posedge ap_clk); #1;
        req_valid[0] = 1'b0;
        checks++; if (fifo_fill !== 5'd1 || cache_req_valid !== 1'b0)
            begin errors++; $display("FAIL wrap_accept got fill %0d valid %0b exp 1 0", fifo_fill, cache_req_valid); end
        @(posedge ap_clk); #1;
        checks++; if (cache_req_valid !== 1'b1 || cache_req_addr !== 64'h10 || cache_req_id !== 2'd0 || fifo_fill !== 5'd0)
            begin errors++; $display("FAIL wrap_issue got valid %0b addr %h id %0d fill %0d exp 1 10 0 0", cache_req_valid, cache_req_addr, cache_req_id, fifo_fill); end
        @(posedge ap_clk); #1;
        checks++; if (cache_req_valid !== 1'b1 || cache_req_addr !== 64'h10)
            begin errors++; $display("FAIL wrap_hold got valid %0b addr %h exp 1 10", cache_req_valid, cache_req_addr); end
        cache_req_ready = 1'b1;
        @(posedge ap_clk); #1;
        cache_req_ready = 1'b0;
        checks++; if (cache_req_valid !== 1'b0 || outstanding_count !== 3'd1)
            begin errors++; $display("FAIL wrap_fire got valid %0b out %0d exp 0 1", cache_req_valid, outstanding_count); end
    endtask

    task automatic test_credit_limit();
        logic [AW-1:0] a5;
        do_reset();
        rem[0] = 8; load_gen(0); cache_req_ready = 1'b1;
        repeat (30) cycle();
        checks++; if (log_id.size() != 4) begin errors++; $display("FAIL limit_count got %0d exp 4", log_id.size()); end
        checks++; if (outstanding_count !== 3'd4 || cache_req_valid !== 1'b0 || fifo_fill !== 5'd4)
            begin errors++; $display("FAIL limit_state got out %0d valid %0b fill %0d exp 4 0 4", outstanding_count, cache_req_valid, fifo_fill); end
        cache_resp_valid = 1'b1;
        cycle();
        cache_resp_valid = 1'b0;
        checks++; if (outstanding_count !== 3'd3 || cache_req_valid !== 1'b1 || log_id.size() != 4)
            begin errors++; $display("FAIL limit_resp got out %0d valid %0b n %0d exp 3 1 4", outstanding_count, cache_req_valid, log_id.size()); end
        cycle();
        a5 = (log_addr.size() > 4) ? log_addr[4] : '1;
        checks++; if (log_id.size() != 5 || outstanding_count !== 3'd4 || a5 !== 64'h104)
            begin errors++; $display("FAIL limit_fifth got n %0d out %0d addr %h exp 5 4 104", log_id.size(), outstanding_count, a5); end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int c = 0; c < N; c++) begin rem[c] = 5; load_gen(c); end
        repeat (40) cycle();
        checks++; if (fifo_fill !== 5'd16 || req_ready !== 4'b0000 || req_valid !== 4'b1110)
            begin errors++; $display("FAIL bp_full got fill %0d ready %b valid %b exp 16 0000 1110", fifo_fill, req_ready, req_valid); end
        checks++; if (cache_req_valid !== 1'b1 || cache_req_addr !== 64'h100 || cache_req_id !== 2'd0)
            begin errors++; $display("FAIL bp_head got valid %0b addr %h id %0d exp 1 100 0", cache_req_valid, cache_req_addr, cache_req_id); end
        repeat (5) cycle();
        checks++; if (cache_req_addr !== 64'h100 || cache_req_id !== 2'd0 || fifo_fill !== 5'd16)
            begin errors++; $display("FAIL bp_stable got addr %h id %0d fill %0d exp 100 0 16", cache_req_addr, cache_req_id, fifo_fill); end
        cache_req_ready = 1'b1; auto_resp = 1'b1;
        for (int i = 0; i < 80 && log_id.size() < 20; i++) cycle();
        repeat (3) cycle();
        checks++; if (log_id.size() != 20 || fifo_fill !== 5'd0)
            begin errors++; $display("FAIL bp_drain got n %0d fill %0d exp 20 0", log_id.size(), fifo_fill); end
        for (int i = 0; i < log_id.size(); i++) begin
            checks++; if (log_id[i] !== IW'(i % 4) || log_addr[i] !== (64'(i % 4) << 32) + 64'h100 + 64'(i / 4))
                begin errors++; $display("FAIL bp_order[%0d] got id %0d addr %h exp %0d %h", i, log_id[i], log_addr[i], i % 4, (64'(i % 4) << 32) + 64'h100 + 64'(i / 4)); end
        end
    endtask

    task automatic test_credit_error();
        do_reset();
        cache_resp_valid = 1'b1;
        @(posedge ap_clk); #1;
        cache_resp_valid = 1'b0;
        checks++; if (credit_error !== 1'b1 || outstanding_count !== 3'd0)
            begin errors++; $display("FAIL cerr_set got err %0b out %0d exp 1 0", credit_error, outstanding_count); end
        rem[1] = 2; load_gen(1);
        repeat (6) cycle();
        checks++; if (outstanding_count !== 3'd0 || cache_req_valid !== 1'b1 || fifo_fill !== 5'd1)
            begin errors++; $display("FAIL cerr_queued got out %0d valid %0b fill %0d exp 0 1 1", outstanding_count, cache_req_valid, fifo_fill); end
        cache_req_ready = 1'b1;
        cycle();
        checks++; if (outstanding_count !== 3'd1) begin errors++; $display("FAIL cerr_issue got %0d exp 1", outstanding_count); end
        cache_resp_valid = 1'b1;
        cycle();
        cache_resp_valid = 1'b0; cache_req_ready = 1'b0;
        checks++; if (outstanding_count !== 3'd1 || log_id.size() != 2 || credit_error !== 1'b1)
            begin errors++; $display("FAIL cerr_simul got out %0d n %0d err %0b exp 1 2 1", outstanding_count, log_id.size(), credit_error); end
    endtask

    task automatic test_write_and_reset();
        do_reset();
        checks++; if (credit_error !== 1'b0) begin errors++; $display("FAIL cerr_clear got %0b exp 0", credit_error); end
        req_we[2] = 1'b1; req_wdata[2*DW +: DW] = 512'hA5; req_wstrb[2*SW +: SW] = 64'hF;
        req_base[2*AW +: AW] = 64'h1000; req_offset[2*AW +: AW] = 64'h40; req_valid[2] = 1'b1; rem[2] = 1;
        repeat (4) cycle();
        checks++; if (cache_req_valid !== 1'b1 || cache_req_we !== 1'b1 || cache_req_id !== 2'd2 || cache_req_addr !== 64'h1040)
            begin errors++; $display("FAIL wr_ctrl got valid %0b we %0b id %0d addr %h exp 1 1 2 1040", cache_req_valid, cache_req_we, cache_req_id, cache_req_addr); end
        checks++; if (cache_req_wdata !== 512'hA5 || cache_req_wstrb !== 64'hF)
            begin errors++; $display("FAIL wr_data got wdata %h wstrb %h exp a5 f", cache_req_wdata[31:0], cache_req_wstrb); end
        rem[0] = 5; load_gen(0);
        repeat (10) cycle();
        checks++; if (fifo_fill !== 5'd5) begin errors++; $display("FAIL wr_queued got %0d exp 5", fifo_fill); end
        areset = 1'b1; req_valid = '0; rem[0] = 0;
        @(posedge ap_clk); #1;
        checks++; if (fifo_fill !== 5'd0 || cache_req_valid !== 1'b0 || fifo_setup_signal !== 1'b1 || cache_req_we !== 1'b0)
            begin errors++; $display("FAIL mid_reset got fill %0d valid %0b setup %0b we %0b exp 0 0 1 0", fifo_fill, cache_req_valid, fifo_setup_signal, cache_req_we); end
        areset = 1'b0;
        @(posedge ap_clk); #1;
        checks++; if (fifo_setup_signal !== 1'b1 || cache_req_valid !== 1'b0)
            begin errors++; $display("FAIL mid_setup1 got setup %0b valid %0b exp 1 0", fifo_setup_signal, cache_req_valid); end
        @(posedge ap_clk); #1;
        checks++; if (fifo_setup_signal !== 1'b0) begin errors++; $display("FAIL mid_setup2 got %0b exp 0", fifo_setup_signal); end
        repeat (3) @(posedge ap_clk); #1;
        checks++; if (cache_req_valid !== 1'b0 || outstanding_count !== 3'd0 || fifo_fill !== 5'd0)
            begin errors++; $display("FAIL mid_abandon got valid %0b out %0d fill %0d exp 0 0 0", cache_req_valid, outstanding_count, fifo_fill); end
    endtask

    initial begin
        cyc = 0;
        test_reset();
        test_round_robin();
        test_addr_wrap();
        test_credit_limit();
        test_backpressure();
        test_credit_error();
        test_write_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
